// File: rtl/rmgmt_mem_arb_pkg.sv
// Types and constants for the data-memory arbiter between the pipeline and RISC-MGMT.
package rmgmt_mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PIPE_XFER = 2'd1,
        RM_XFER   = 2'd2,
        FAULT     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_RM   = 1'b1
    } owner_t;

    localparam int ARB_PIPE_PRIO = 0;
    localparam int ARB_RM_PRIO   = 1;
    localparam int ARB_RR        = 2;

    // Wait-counter width; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction
endpackage

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scalar types used across the core's memory-side blocks.
package rv32i_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/rmgmt_mem_arbiter_bus_timeout_counter.sv
// Saturating busy-cycle counter; expired_o flags the cycle whose count reaches MAX_WAIT.
module bus_timeout_counter
    import rmgmt_mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i && (cnt_q != SAT))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (MAX_WAIT != 0) && enable_i && (cnt_d == SAT);
endmodule

// File: rtl/rmgmt_mem_arbiter.sv
// Grants the data bus to the pipeline or the RISC-MGMT port, forwards the transfer,
// and reports rejected RISC-MGMT requests and timed-out transfers as one-cycle faults.
module rmgmt_mem_arbiter
    import rmgmt_mem_arb_pkg::*;
    import rv32i_types_pkg::*;
#(
    parameter int ARB_MODE = 2,
    parameter int MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pipe_ren,
    input  logic        pipe_wen,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    input  logic [3:0]  pipe_byte_en,
    output logic [31:0] pipe_rdata,
    output logic        pipe_busy,
    output logic        pipe_fault,
    input  logic        rm_req_mem,
    input  logic        rm_mem_ren,
    input  logic        rm_mem_wen,
    input  logic [31:0] rm_mem_addr,
    input  logic [31:0] rm_mem_store,
    output logic [31:0] rm_mem_load,
    output logic        rm_mem_busy,
    output logic        rm_fault,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy
);
    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_q, last_d;

    logic  pipe_vld, rm_vld, both_vld, rm_bad, rm_wins;
    logic  in_xfer, expired;
    word_t rdata_w;

    assign pipe_vld = pipe_ren | pipe_wen;
    assign rm_vld   = rm_req_mem & (rm_mem_ren | rm_mem_wen);
    assign both_vld = pipe_vld & rm_vld;
    assign rm_bad   = (rm_mem_addr[1:0] != 2'b00) || (rm_mem_ren && rm_mem_wen);
    assign in_xfer  = (state_q == PIPE_XFER) || (state_q == RM_XFER);
    assign rdata_w  = bus_busy ? '0 : bus_rdata;

    always_comb begin
        rm_wins = rm_vld;
        if (both_vld) begin
            if (ARB_MODE == ARB_PIPE_PRIO)
                rm_wins = 1'b0;
            else if (ARB_MODE == ARB_RM_PRIO)
                rm_wins = 1'b1;
            else
                rm_wins = (last_q == OWN_PIPE);
        end
    end

    bus_timeout_counter #(.MAX_WAIT(MAX_WAIT)) u_timeout (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (!in_xfer),
        .enable_i  (in_xfer && bus_busy),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pipe_vld || rm_vld) begin
                    owner_d = rm_wins ? OWN_RM : OWN_PIPE;
                    if (both_vld)
                        last_d = owner_d;
                    // Bad RISC-MGMT requests are only rejected once they actually win.
                    if (!rm_wins)
                        state_d = PIPE_XFER;
                    else if (rm_bad)
                        state_d = FAULT;
                    else
                        state_d = RM_XFER;
                end
            end
            PIPE_XFER, RM_XFER: begin
                if (!bus_busy)
                    state_d = IDLE;
                else if (expired)
                    state_d = FAULT;
            end
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= OWN_PIPE;
            last_q  <= OWN_RM;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Idle (and reset) behaviour is the default: strobes off, busy mirrors request-valid.
    always_comb begin
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_byte_en = '0;
        bus_ren     = 1'b0;
        bus_wen     = 1'b0;
        pipe_busy   = pipe_vld;
        rm_mem_busy = rm_vld;
        pipe_rdata  = '0;
        rm_mem_load = '0;
        pipe_fault  = 1'b0;
        rm_fault    = 1'b0;
        if (!RST) begin
            case (state_q)
                PIPE_XFER: begin
                    bus_addr    = pipe_addr;
                    bus_wdata   = pipe_wdata;
                    bus_byte_en = pipe_byte_en;
                    bus_ren     = pipe_ren;
                    bus_wen     = pipe_wen;
                    pipe_busy   = bus_busy;
                    pipe_rdata  = rdata_w;
                end
                RM_XFER: begin
                    bus_addr    = rm_mem_addr;
                    bus_wdata   = rm_mem_store;
                    bus_byte_en = 4'hF;
                    bus_ren     = rm_mem_ren;
                    bus_wen     = rm_mem_wen;
                    rm_mem_busy = bus_busy;
                    rm_mem_load = rdata_w;
                end
                FAULT: begin
                    if (owner_q == OWN_RM) begin
                        rm_mem_busy = 1'b0;
                        rm_fault    = 1'b1;
                    end else begin
                        pipe_busy   = 1'b0;
                        pipe_fault  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rmgmt_mem_arbiter.sv
// Directed and randomized checks of the pipeline / RISC-MGMT data-bus arbiter.
module tb_rmgmt_mem_arbiter;
  localparam int MAXW = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        pipe_ren = 0, pipe_wen = 0;
  logic [31:0] pipe_addr = 0, pipe_wdata = 0;
  logic [3:0]  pipe_byte_en = 0;
  logic [31:0] pipe_rdata;
  logic        pipe_busy, pipe_fault;
  logic        rm_req_mem = 0, rm_mem_ren = 0, rm_mem_wen = 0;
  logic [31:0] rm_mem_addr = 0, rm_mem_store = 0;
  logic [31:0] rm_mem_load;
  logic        rm_mem_busy, rm_fault;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_ren, bus_wen;
  logic [31:0] bus_rdata = 0;
  logic        bus_busy = 0;

  int checks = 0;
  int errs = 0;
  int lat_p = 0, lat_r = 0, rcnt = 0;
  logic [31:0] dat_p = 0, dat_r = 0;
  int m_last = 1;  // 1 = RISC-MGMT won the last contest

  rmgmt_mem_arbiter #(.ARB_MODE(2), .MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RST(RST),
    .pipe_ren(pipe_ren), .pipe_wen(pipe_wen), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_byte_en(pipe_byte_en), .pipe_rdata(pipe_rdata),
    .pipe_busy(pipe_busy), .pipe_fault(pipe_fault),
    .rm_req_mem(rm_req_mem), .rm_mem_ren(rm_mem_ren), .rm_mem_wen(rm_mem_wen),
    .rm_mem_addr(rm_mem_addr), .rm_mem_store(rm_mem_store), .rm_mem_load(rm_mem_load),
    .rm_mem_busy(rm_mem_busy), .rm_fault(rm_fault),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_rdata(bus_rdata), .bus_busy(bus_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock; then the bus model answers: busy for lat cycles of a transfer, then data.
  task automatic tick();
    logic is_p;
    @(posedge CLK);
    #1;
    if (bus_ren || bus_wen) begin
      is_p = (bus_addr == pipe_addr);
      bus_busy = (rcnt < (is_p ? lat_p : lat_r));
      bus_rdata = bus_busy ? 32'h0 : (is_p ? dat_p : dat_r);
      rcnt++;
    end else begin
      rcnt = 0;
      bus_busy = 1'b0;
      bus_rdata = 32'h0;
    end
    #1;
  endtask

  task automatic drop_pipe();
    pipe_ren = 0; pipe_wen = 0; pipe_addr = 0;
  endtask

  task automatic drop_rm();
    rm_req_mem = 0; rm_mem_ren = 0; rm_mem_wen = 0; rm_mem_addr = 0;
  endtask

  function automatic int dur(input int lat);
    return (lat < MAXW) ? lat : MAXW;
  endfunction

  task automatic drain();
    int c = 0;
    while ((pipe_ren || pipe_wen || rm_req_mem) && c < 40) begin
      tick(); c++;
      if (!pipe_busy) drop_pipe();
      if (!rm_mem_busy) drop_rm();
    end
    check("drain_done", {31'b0, pipe_ren | pipe_wen | rm_req_mem}, 32'h0);
  endtask

  task automatic rand_trial();
    int sel, k, c, pc, rc, ep, er, t_first, d_p, d_r;
    logic pv, rv, rbad, rm_first, pdone, rdone, pf, rf, epf, erf;
    logic [31:0] prd, rrd, eprd, errd, mis;
    tick();
    sel = $urandom_range(0, 2);
    pv = (sel != 1); rv = (sel != 0);
    lat_p = $urandom_range(0, 5); lat_r = $urandom_range(0, 5);
    dat_p = $urandom(); dat_r = $urandom();
    if (pv) begin
      k = $urandom_range(0, 2);
      pipe_ren = (k != 1); pipe_wen = (k != 0);
      pipe_addr = ($urandom() & 32'h7FFF_FFFF) | 32'h4;
      pipe_wdata = $urandom(); pipe_byte_en = 4'($urandom_range(0, 15));
    end
    rbad = 1'b0;
    if (rv) begin
      k = $urandom_range(0, 7);
      rm_req_mem = 1; rm_mem_ren = (k <= 3); rm_mem_wen = (k == 0) || (k >= 4);
      mis = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
      rm_mem_addr = ($urandom() & 32'h7FFF_FFFC) | 32'h8000_0000 | mis;
      rm_mem_store = $urandom();
      rbad = (mis != 0) || (rm_mem_ren && rm_mem_wen);
    end
    // Reference: each service takes one idle cycle plus its bus time; a rejected request none.
    if (pv && rv) begin
      rm_first = (m_last == 0);
      m_last = rm_first ? 1 : 0;
    end else rm_first = rv;
    d_p = 1 + dur(lat_p);
    d_r = 1 + (rbad ? 0 : dur(lat_r));
    epf = (lat_p >= MAXW);
    erf = rbad || (lat_r >= MAXW);
    eprd = epf ? 32'h0 : dat_p;
    errd = erf ? 32'h0 : dat_r;
    t_first = rm_first ? d_r : d_p;
    ep = rm_first ? t_first + 1 + d_p : d_p;
    er = rm_first ? d_r : t_first + 1 + d_r;
    pdone = !pv; rdone = !rv; c = 0;
    pc = -1; rc = -1; pf = 0; rf = 0; prd = 0; rrd = 0;
    while (!(pdone && rdone) && c < 40) begin
      tick(); c++;
      if (!pdone && !pipe_busy) begin
        pc = c; pf = pipe_fault; prd = pipe_rdata; pdone = 1; drop_pipe();
      end
      if (!rdone && !rm_mem_busy) begin
        rc = c; rf = rm_fault; rrd = rm_mem_load; rdone = 1; drop_rm();
      end
    end
    if (pv) begin
      check("rand_pipe_cycle", pc, ep);
      check("rand_pipe_fault", {31'b0, pf}, {31'b0, epf});
      check("rand_pipe_rdata", prd, eprd);
    end
    if (rv) begin
      check("rand_rm_cycle", rc, er);
      check("rand_rm_fault", {31'b0, rf}, {31'b0, erf});
      check("rand_rm_load", rrd, errd);
    end
    drop_pipe(); drop_rm();
  endtask

  initial begin
    // Reset: busy follows request-valid while RST is high, outputs idle afterwards.
    pipe_ren = 1;
    tick();
    check("rst_pipe_busy", pipe_busy, 1);
    check("rst_rm_busy", rm_mem_busy, 0);
    check("rst_bus_ren", bus_ren, 0);
    pipe_ren = 0; RST = 0; #1;
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_byte_en", bus_byte_en, 0);
    check("rst_pipe_rdata", pipe_rdata, 0);
    check("rst_faults", {30'b0, pipe_fault, rm_fault}, 0);

    // Minimum-latency pipeline load.
    tick();
    pipe_ren = 1; pipe_addr = 32'h100; lat_p = 0; dat_p = 32'hDEADBEEF; #1;
    check("ld_idle_busy", pipe_busy, 1);
    check("ld_idle_ren", bus_ren, 0);
    tick();
    check("ld_bus_ren", bus_ren, 1);
    check("ld_bus_addr", bus_addr, 32'h100);
    check("ld_busy", pipe_busy, 0);
    check("ld_rdata", pipe_rdata, 32'hDEADBEEF);
    drop_pipe();
    tick();
    check("ld_after_rdata", pipe_rdata, 0);

    // Contest after reset: pipeline first, RISC-MGMT waits, then RISC-MGMT wins the next.
    pipe_wen = 1; pipe_addr = 32'h300; pipe_wdata = 32'hCAFE0001; pipe_byte_en = 4'h3; lat_p = 1;
    rm_req_mem = 1; rm_mem_ren = 1; rm_mem_addr = 32'h400; lat_r = 0; dat_r = 32'h0BADF00D;
    tick();
    check("rr1_bus_wen", bus_wen, 1);
    check("rr1_bus_addr", bus_addr, 32'h300);
    check("rr1_bus_wdata", bus_wdata, 32'hCAFE0001);
    check("rr1_byte_en", bus_byte_en, 4'h3);
    check("rr1_pipe_busy", pipe_busy, 1);
    check("rr1_rm_busy", rm_mem_busy, 1);
    tick();
    check("rr2_pipe_busy", pipe_busy, 0);
    check("rr2_rm_busy", rm_mem_busy, 1);
    drop_pipe();
    tick();
    check("rr3_rm_busy", rm_mem_busy, 1);
    check("rr3_bus_ren", bus_ren, 0);
    tick();
    check("rr4_bus_ren", bus_ren, 1);
    check("rr4_byte_en", bus_byte_en, 4'hF);
    check("rr4_rm_busy", rm_mem_busy, 0);
    check("rr4_rm_load", rm_mem_load, 32'h0BADF00D);
    drop_rm();
    tick();
    pipe_ren = 1; pipe_addr = 32'h500; lat_p = 0;
    rm_req_mem = 1; rm_mem_ren = 1; rm_mem_addr = 32'h600; lat_r = 0;
    tick();
    check("rr5_rm_wins", bus_addr, 32'h600);
    check("rr5_pipe_busy", pipe_busy, 1);
    drain();

    // Misaligned RISC-MGMT load is rejected without touching the bus.
    tick();
    rm_req_mem = 1; rm_mem_ren = 1; rm_mem_addr = 32'h102;
    tick();
    check("mis_strobes", {30'b0, bus_ren, bus_wen}, 0);
    check("mis_rm_fault", rm_fault, 1);
    check("mis_rm_busy", rm_mem_busy, 0);
    check("mis_rm_load", rm_mem_load, 0);
    check("mis_pipe_fault", pipe_fault, 0);
    drop_rm();
    tick();
    check("mis_fault_clr", rm_fault, 0);

    // Stuck bus: fault after MAXW busy cycles, strobes drop with it.
    tick();
    pipe_ren = 1; pipe_addr = 32'h700; lat_p = 100;
    for (int i = 1; i <= MAXW; i++) begin
      tick();
      check($sformatf("to_busy%0d", i), {31'b0, pipe_busy}, 1);
      check($sformatf("to_ren%0d", i), {31'b0, bus_ren}, 1);
    end
    tick();
    check("to_fault", pipe_fault, 1);
    check("to_busy_drop", pipe_busy, 0);
    check("to_ren_drop", bus_ren, 0);
    check("to_rdata", pipe_rdata, 0);
    drop_pipe();
    tick();
    check("to_fault_clr", pipe_fault, 0);

    // RISC-MGMT store with three busy cycles completes just under the timeout.
    rm_req_mem = 1; rm_mem_wen = 1; rm_mem_addr = 32'h200; rm_mem_store = 32'h12345678; lat_r = 3;
    tick();
    check("st_byte_en", bus_byte_en, 4'hF);
    check("st_wdata", bus_wdata, 32'h12345678);
    check("st_wen", bus_wen, 1);
    check("st_busy1", rm_mem_busy, 1);
    tick();
    check("st_busy2", rm_mem_busy, 1);
    tick();
    check("st_busy3", rm_mem_busy, 1);
    tick();
    check("st_done", rm_mem_busy, 0);
    check("st_no_fault", rm_fault, 0);
    drop_rm();

    // Reset in the middle of a RISC-MGMT transfer, then re-arbitration.
    tick();
    rm_req_mem = 1; rm_mem_ren = 1; rm_mem_addr = 32'h800; lat_r = 100; dat_r = 32'h55AA55AA;
    tick();
    check("rx_xfer_ren", bus_ren, 1);
    RST = 1; #1;
    check("rx_rst_busy", rm_mem_busy, 1);
    tick();
    RST = 0; #1;
    check("rx_strobes_off", bus_ren, 0);
    check("rx_busy_held", rm_mem_busy, 1);
    lat_r = 0;
    tick();
    check("rx_ren_again", bus_ren, 1);
    check("rx_done", rm_mem_busy, 0);
    check("rx_load", rm_mem_load, 32'h55AA55AA);
    drop_rm();

    // Randomized traffic against the transaction-level model.
    RST = 1;
    tick();
    RST = 0;
    m_last = 1;
    for (int t = 0; t < 40; t++) rand_trial();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
